// File: rtl/pipe_stage_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stage_ctrl
//
// Consumer side of the hazard control interface. This block owns the valid
// bits and the hazard-relevant tag fields of the four pipeline registers
// (IF/ID, ID/EX, EX/MEM, MEM/WB). It applies the hazard detector's controls
// on every rising edge and feeds the IF/ID and ID/EX tags back to the
// detector. It also keeps saturating stall, flush and retire counters for
// performance bring-up, and a sticky flag for an illegal control combination.
//
// Ports
//   clk, rst_n              single clock; synchronous active-low reset
//   pc_write_en             PC may advance (0 with if_id_write_en=0 is a stall)
//   if_id_write_en          IF/ID loads the fetch slot
//   id_ex_flush             bubble into ID/EX
//   ex_mem_flush            bubble into EX/MEM
//   fetch_*                 fetch slot: valid, PC, opcode, Rn/Rm/Rd, load flag
//   valid_ifid, pc_ifid, opcode_ifid, Rn_ifid, Rm_ifid   IF/ID tags
//   valid_idex, opcode_idex, Rd_idex, mem_read_en_idex   ID/EX tags
//   valid_exmem, Rd_exmem   EX/MEM tags
//   valid_memwb, Rd_memwb   MEM/WB tags
//   stall_count, flush_count, retire_count   saturating counters
//   protocol_err            sticky: if_id_write_en=1 seen with pc_write_en=0
// -----------------------------------------------------------------------------
module pipe_stage_ctrl #(
    parameter int          OPCODE_W   = 5,
    parameter int          REG_W      = 4,
    parameter int          PC_W       = 32,
    parameter int          CNT_W      = 16,
    parameter int unsigned NOP_OPCODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,

    // Hazard controls
    input  logic                pc_write_en,
    input  logic                if_id_write_en,
    input  logic                id_ex_flush,
    input  logic                ex_mem_flush,

    // Fetch slot
    input  logic                fetch_valid,
    input  logic [PC_W-1:0]     fetch_pc,
    input  logic [OPCODE_W-1:0] fetch_opcode,
    input  logic [REG_W-1:0]    fetch_Rn,
    input  logic [REG_W-1:0]    fetch_Rm,
    input  logic [REG_W-1:0]    fetch_Rd,
    input  logic                fetch_mem_read,

    // IF/ID tags
    output logic                valid_ifid,
    output logic [PC_W-1:0]     pc_ifid,
    output logic [OPCODE_W-1:0] opcode_ifid,
    output logic [REG_W-1:0]    Rn_ifid,
    output logic [REG_W-1:0]    Rm_ifid,

    // ID/EX tags
    output logic                valid_idex,
    output logic [OPCODE_W-1:0] opcode_idex,
    output logic [REG_W-1:0]    Rd_idex,
    output logic                mem_read_en_idex,

    // EX/MEM and MEM/WB tags
    output logic                valid_exmem,
    output logic [REG_W-1:0]    Rd_exmem,
    output logic                valid_memwb,
    output logic [REG_W-1:0]    Rd_memwb,

    // Performance counters and error flag
    output logic [CNT_W-1:0]    stall_count,
    output logic [CNT_W-1:0]    flush_count,
    output logic [CNT_W-1:0]    retire_count,
    output logic                protocol_err
);

    localparam logic [OPCODE_W-1:0] NOP = OPCODE_W'(NOP_OPCODE);

    // -------------------------------------------------------------------------
    // Stage register layouts. IF/ID also carries Rd and the load flag from
    // fetch so that ID/EX can capture them one edge later.
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic                valid;
        logic [PC_W-1:0]     pc;
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rn;
        logic [REG_W-1:0]    rm;
        logic [REG_W-1:0]    rd;
        logic                mem_read;
    } ifid_t;

    typedef struct packed {
        logic                valid;
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rd;
        logic                mem_read;   // already qualified by valid
    } idex_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } tail_t;

    localparam ifid_t IFID_RESET = '{valid: 1'b0, pc: '0, opcode: NOP,
                                     rn: '0, rm: '0, rd: '0, mem_read: 1'b0};
    localparam idex_t IDEX_BUBBLE = '{valid: 1'b0, opcode: NOP, rd: '0,
                                      mem_read: 1'b0};
    localparam tail_t TAIL_BUBBLE = '{valid: 1'b0, rd: '0};

    ifid_t ifid_q,  ifid_d;
    idex_t idex_q,  idex_d;
    tail_t exmem_q, exmem_d;
    tail_t memwb_q, memwb_d;

    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic             protocol_err_q, protocol_err_d;

    logic stall_event;
    logic illegal_ctrl;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             en);
        if (en && (value != '1)) begin
            return value + CNT_W'(1);
        end
        return value;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic. Every stage is computed from pre-edge register values
    // so the whole pipeline advances in lock step.
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ifid_d         = ifid_q;
        idex_d         = idex_q;
        exmem_d        = exmem_q;
        memwb_d        = memwb_q;
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        retire_cnt_d   = retire_cnt_q;
        protocol_err_d = protocol_err_q;
        stall_event    = 1'b0;
        illegal_ctrl   = 1'b0;

        // IF/ID: write enable wins, even in the illegal combination. Without
        // it, an advancing PC means the fetched-behind slot is a wrong-path
        // instruction and is killed in place; otherwise it is a load-use hold.
        if (if_id_write_en) begin
            ifid_d.valid    = fetch_valid;
            ifid_d.pc       = fetch_pc;
            ifid_d.opcode   = fetch_opcode;
            ifid_d.rn       = fetch_Rn;
            ifid_d.rm       = fetch_Rm;
            ifid_d.rd       = fetch_Rd;
            ifid_d.mem_read = fetch_mem_read;
        end else if (pc_write_en) begin
            ifid_d.valid = 1'b0;
        end

        // ID/EX: Rd and the load flag are zeroed for an invalid source so
        // downstream forwarding and load-use detection never match it.
        if (id_ex_flush) begin
            idex_d = IDEX_BUBBLE;
        end else begin
            idex_d.valid    = ifid_q.valid;
            idex_d.opcode   = ifid_q.opcode;
            idex_d.rd       = ifid_q.valid ? ifid_q.rd : '0;
            idex_d.mem_read = ifid_q.valid & ifid_q.mem_read;
        end

        // EX/MEM: ID/EX already carries Rd=0 when invalid.
        if (ex_mem_flush) begin
            exmem_d = TAIL_BUBBLE;
        end else begin
            exmem_d.valid = idex_q.valid;
            exmem_d.rd    = idex_q.rd;
        end

        // MEM/WB is never stalled or flushed; on a double flush it still
        // captures the instruction that was in EX/MEM before the edge.
        memwb_d = exmem_q;

        // Counters and error flag.
        stall_event    = !pc_write_en && !if_id_write_en;
        illegal_ctrl   = if_id_write_en && !pc_write_en;
        stall_cnt_d    = sat_inc(stall_cnt_q, stall_event);
        flush_cnt_d    = sat_inc(flush_cnt_q, ex_mem_flush);
        retire_cnt_d   = sat_inc(retire_cnt_q, memwb_q.valid);
        protocol_err_d = protocol_err_q | illegal_ctrl;
    end

    // -------------------------------------------------------------------------
    // State registers. Reset discards every stage regardless of the controls
    // presented in the same cycle.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all stages
    // sample pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_q         <= IFID_RESET;
            idex_q         <= IDEX_BUBBLE;
            exmem_q        <= TAIL_BUBBLE;
            memwb_q        <= TAIL_BUBBLE;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            retire_cnt_q   <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            ifid_q         <= ifid_d;
            idex_q         <= idex_d;
            exmem_q        <= exmem_d;
            memwb_q        <= memwb_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            retire_cnt_q   <= retire_cnt_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign valid_ifid       = ifid_q.valid;
    assign pc_ifid          = ifid_q.pc;
    assign opcode_ifid      = ifid_q.opcode;
    assign Rn_ifid          = ifid_q.rn;
    assign Rm_ifid          = ifid_q.rm;

    assign valid_idex       = idex_q.valid;
    assign opcode_idex      = idex_q.opcode;
    assign Rd_idex          = idex_q.rd;
    assign mem_read_en_idex = idex_q.mem_read;

    assign valid_exmem      = exmem_q.valid;
    assign Rd_exmem         = exmem_q.rd;
    assign valid_memwb      = memwb_q.valid;
    assign Rd_memwb         = memwb_q.rd;

    assign stall_count      = stall_cnt_q;
    assign flush_count      = flush_cnt_q;
    assign retire_count     = retire_cnt_q;
    assign protocol_err     = protocol_err_q;

endmodule
